// File: rtl/sgdmac_pkg.sv
// Shared types and constants for the scatter-gather DMA descriptor path.
package sgdmac_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = ADDR_W + LEN_W;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    // Word slot of each descriptor field, in beat order
    localparam logic [1:0] DESC_W_SRC  = 2'd0;
    localparam logic [1:0] DESC_W_DST  = 2'd1;
    localparam logic [1:0] DESC_W_CTRL = 2'd2;
    localparam logic [1:0] DESC_W_NEXT = 2'd3;

    localparam int unsigned CTRL_LAST_BIT = 31;
    localparam int unsigned CTRL_LEN_LSB  = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } sgdmac_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PUSH,
        ST_DONE,
        ST_ERR
    } sgdmac_state_t;

endpackage

// File: rtl/sgdmac_desc_parser.sv
// Assembles 4-beat descriptors from AXI R beats and splits each into
// paired read/write commands plus a next-descriptor pointer.
module sgdmac_desc_parser
    import sgdmac_pkg::*;
#(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [3:0]        rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic              rd_afull_i,
    input  logic              wr_afull_i,
    output logic              rd_wren_o,
    output logic [CMD_W-1:0]  rd_cmd_o,
    output logic              wr_wren_o,
    output logic [CMD_W-1:0]  wr_cmd_o,
    output logic              next_valid_o,
    output logic [ADDR_W-1:0] next_ptr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    sgdmac_state_t     state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] next_q;
    logic [LEN_W-1:0]  len_q;
    logic              last_q;
    logic              done_q;
    logic              err_q;

    logic        beat_acc;
    logic        beat_bad;
    logic        has_len;
    logic        fifo_free;
    logic        push_leave;
    logic        push_fire;
    sgdmac_cmd_t rd_cmd;
    sgdmac_cmd_t wr_cmd;

    assign beat_acc   = (state_q == ST_COLLECT) && rvalid_i && (rid_i == ID);
    // rlast must appear on exactly the final beat of a descriptor
    assign beat_bad   = (rresp_i != RRESP_OKAY) || (rlast_i != (cnt_q == DESC_W_NEXT));
    assign has_len    = (len_q != '0);
    assign fifo_free  = !rd_afull_i && !wr_afull_i;
    // Outputs are suppressed in the reset cycle so a stale PUSH cannot leak out
    assign push_leave = (state_q == ST_PUSH) && !rst && (!has_len || fifo_free);
    assign push_fire  = push_leave && has_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            src_q   <= '0;
            dst_q   <= '0;
            next_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        cnt_q   <= 2'd0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (beat_acc) begin
                        if (beat_bad) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            case (cnt_q)
                                DESC_W_SRC:  src_q <= rdata_i;
                                DESC_W_DST:  dst_q <= rdata_i;
                                DESC_W_CTRL: begin
                                    last_q <= rdata_i[CTRL_LAST_BIT];
                                    len_q  <= rdata_i[CTRL_LEN_LSB +: LEN_W];
                                end
                                default:     next_q <= rdata_i;
                            endcase
                            cnt_q <= cnt_q + 2'd1;
                            if (cnt_q == DESC_W_NEXT) begin
                                state_q <= ST_PUSH;
                            end
                        end
                    end
                end
                ST_PUSH: begin
                    if (push_leave) begin
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_cmd = '{addr: src_q, len: len_q};
    assign wr_cmd = '{addr: dst_q, len: len_q};

    assign rready_o     = (state_q == ST_COLLECT);
    assign busy_o       = (state_q == ST_COLLECT) || (state_q == ST_PUSH);
    assign rd_wren_o    = push_fire;
    assign wr_wren_o    = push_fire;
    assign rd_cmd_o     = rd_cmd;
    assign wr_cmd_o     = wr_cmd;
    assign next_valid_o = push_leave && !last_q;
    assign next_ptr_o   = next_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_sgdmac_desc_parser.sv
// Directed bench for sgdmac_desc_parser with a descriptor-level scoreboard.
module tb_sgdmac_desc_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  rid_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        rd_afull_i;
    logic        wr_afull_i;
    logic        rd_wren_o;
    logic [47:0] rd_cmd_o;
    logic        wr_wren_o;
    logic [47:0] wr_cmd_o;
    logic        next_valid_o;
    logic [31:0] next_ptr_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    sgdmac_desc_parser dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .rid_i        (rid_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rlast_i      (rlast_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .rd_afull_i   (rd_afull_i),
        .wr_afull_i   (wr_afull_i),
        .rd_wren_o    (rd_wren_o),
        .rd_cmd_o     (rd_cmd_o),
        .wr_wren_o    (wr_wren_o),
        .wr_cmd_o     (wr_cmd_o),
        .next_valid_o (next_valid_o),
        .next_ptr_o   (next_ptr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected command pairs and next pointers, in order
    logic [47:0] exp_rd[$];
    logic [47:0] exp_wr[$];
    logic [31:0] exp_nv[$];

    int          push_cyc = -1;
    int          push_cnt = 0;
    int          nv_cyc   = -1;
    int          nv_cnt   = 0;
    logic [31:0] nv_ptr   = '0;
    int          last_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("wren_pair", {63'd0, rd_wren_o}, {63'd0, wr_wren_o});
        if (rd_wren_o === 1'b1 || wr_wren_o === 1'b1) begin
            chk("push_while_afull", {63'd0, rd_afull_i | wr_afull_i}, 64'd0);
            chk("rready_during_push", {63'd0, rready_o}, 64'd0);
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push: rd_cmd %0h with nothing expected (cycle %0d)", rd_cmd_o, cyc);
            end else begin
                logic [47:0] er;
                logic [47:0] ew;
                er = exp_rd.pop_front();
                ew = exp_wr.pop_front();
                chk("rd_cmd", {16'd0, rd_cmd_o}, {16'd0, er});
                chk("wr_cmd", {16'd0, wr_cmd_o}, {16'd0, ew});
            end
            push_cyc = cyc;
            push_cnt++;
        end
        if (next_valid_o === 1'b1) begin
            checks++;
            if (exp_nv.size() == 0) begin
                errors++;
                $display("FAIL unexpected_next: ptr %0h with nothing expected (cycle %0d)", next_ptr_o, cyc);
            end else begin
                logic [31:0] en;
                en = exp_nv.pop_front();
                chk("next_ptr", {32'd0, next_ptr_o}, {32'd0, en});
            end
            nv_cyc = cyc;
            nv_ptr = next_ptr_o;
            nv_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    // Present one ID-matching beat until the parser is ready to take it
    task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        bit ok;
        ok       = 1'b0;
        rvalid_i = 1'b1;
        rid_i    = 4'd0;
        rdata_i  = d;
        rresp_i  = resp;
        rlast_i  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rready_o === 1'b1) begin
                ok       = 1'b1;
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        if (!ok) chk("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic foreign_beats(input int n);
        rvalid_i = 1'b1;
        rid_i    = 4'd1;
        rdata_i  = 32'hBAD0_BAD0;
        rresp_i  = 2'b00;
        rlast_i  = 1'b1;
        tick(n);
        rvalid_i = 1'b0;
        rid_i    = 4'd0;
        rlast_i  = 1'b0;
    endtask

    // Model: a descriptor yields a command pair iff its length is nonzero,
    // and a next-pointer hand-off iff its last flag is clear.
    task automatic send_desc(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input int stall);
        if (w2[15:0] != 16'd0) begin
            exp_rd.push_back({w0, w2[15:0]});
            exp_wr.push_back({w1, w2[15:0]});
        end
        if (!w2[31]) exp_nv.push_back(w3);
        send_beat(w0, 2'b00, 1'b0);
        send_beat(w1, 2'b00, 1'b0);
        send_beat(w2, 2'b00, 1'b0);
        if (stall > 0) begin
            rvalid_i = 1'b1;
            rid_i    = 4'd0;
            rdata_i  = w3;
            rresp_i  = 2'b00;
            rlast_i  = 1'b1;
            @(negedge clk);
            last_acc = cyc;
            @(posedge clk);
            #1;
            rvalid_i   = 1'b0;
            rlast_i    = 1'b0;
            rd_afull_i = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_rready", {63'd0, rready_o}, 64'd0);
                chk("stall_no_wren", {63'd0, rd_wren_o | wr_wren_o}, 64'd0);
                @(posedge clk);
                #1;
            end
            rd_afull_i = 1'b0;
        end else begin
            send_beat(w3, 2'b00, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pc;
        int nc;
        rst        = 1'b1;
        start_i    = 1'b0;
        rid_i      = 4'd0;
        rdata_i    = '0;
        rresp_i    = 2'b00;
        rlast_i    = 1'b0;
        rvalid_i   = 1'b0;
        rd_afull_i = 1'b0;
        wr_afull_i = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rready", {63'd0, rready_o}, 64'd0);
        chk("rst_wren", {62'd0, rd_wren_o, wr_wren_o}, 64'd0);
        chk("rst_flags", {60'd0, next_valid_o, busy_o, done_o, err_o}, 64'd0);
        chk("rst_cmds", {16'd0, rd_cmd_o}, 64'd0);
        chk("rst_wcmd", {16'd0, wr_cmd_o}, 64'd0);
        chk("rst_next", {32'd0, next_ptr_o}, 64'd0);
        tick(1);

        // Single last descriptor
        pulse_start();
        send_desc(32'h0000_1000, 32'h0000_2000, 32'h8000_0040, 32'hDEAD_BEEF, 0);
        tick(1);
        chk("t1_push_cycle", 64'(push_cyc), 64'(last_acc + 1));
        chk("t1_rd_cmd", {16'd0, rd_cmd_o}, 64'h0000_0000_1000_0040);
        chk("t1_wr_cmd", {16'd0, wr_cmd_o}, 64'h0000_0000_2000_0040);
        @(negedge clk);
        chk("t1_done", {63'd0, done_o}, 64'd1);
        chk("t1_busy", {63'd0, busy_o}, 64'd0);
        chk("t1_no_next", 64'(nv_cnt), 64'd0);
        tick(1);

        // Two-descriptor chain
        pulse_start();
        send_desc(32'h0000_1100, 32'h0000_2100, 32'h0000_0010, 32'h0000_3000, 0);
        tick(1);
        chk("t2_next_cycle", 64'(nv_cyc), 64'(last_acc + 1));
        chk("t2_next_ptr", {32'd0, nv_ptr}, 64'h3000);
        @(negedge clk);
        chk("t2_not_done", {63'd0, done_o}, 64'd0);
        chk("t2_rready_back", {63'd0, rready_o}, 64'd1);
        pc = push_cnt;
        tick(1);
        send_desc(32'h0000_1200, 32'h0000_2200, 32'h8000_0020, 32'h0, 0);
        tick(1);
        chk("t2_second_push", 64'(push_cnt), 64'(pc + 1));
        @(negedge clk);
        chk("t2_done", {63'd0, done_o}, 64'd1);
        tick(1);

        // Almost-full stall during PUSH
        pulse_start();
        send_desc(32'h0000_5000, 32'h0000_6000, 32'h8000_0100, 32'h0, 5);
        tick(2);
        chk("t3_push_cycle", 64'(push_cyc), 64'(last_acc + 6));
        chk("t3_rd_cmd", {16'd0, rd_cmd_o}, 64'h0000_0000_5000_0100);
        @(negedge clk);
        chk("t3_done", {63'd0, done_o}, 64'd1);
        tick(1);

        // Bus error on beat 1
        pulse_start();
        pc = push_cnt;
        send_beat(32'h0000_AAAA, 2'b00, 1'b0);
        send_beat(32'h0000_BBBB, 2'b10, 1'b0);
        @(negedge clk);
        chk("t4_err", {63'd0, err_o}, 64'd1);
        chk("t4_rready", {63'd0, rready_o}, 64'd0);
        chk("t4_busy", {63'd0, busy_o}, 64'd0);
        tick(4);
        chk("t4_no_push", 64'(push_cnt), 64'(pc));
        pulse_start();
        @(negedge clk);
        chk("t4_err_cleared", {63'd0, err_o}, 64'd0);
        chk("t4_rready_on", {63'd0, rready_o}, 64'd1);
        tick(1);
        send_desc(32'h0000_1300, 32'h0000_2300, 32'h8000_0008, 32'h0, 0);
        tick(1);
        chk("t4_recover_push", 64'(push_cnt), 64'(pc + 1));
        tick(1);

        // Foreign-ID beats interleaved, then a zero-length non-last descriptor
        pulse_start();
        exp_rd.push_back({32'h0000_1400, 16'h0080});
        exp_wr.push_back({32'h0000_2400, 16'h0080});
        exp_nv.push_back(32'h0000_4000);
        send_beat(32'h0000_1400, 2'b00, 1'b0);
        foreign_beats(2);
        send_beat(32'h0000_2400, 2'b00, 1'b0);
        foreign_beats(1);
        send_beat(32'h0000_0080, 2'b00, 1'b0);
        foreign_beats(3);
        send_beat(32'h0000_4000, 2'b00, 1'b1);
        tick(1);
        chk("t5_push_cycle", 64'(push_cyc), 64'(last_acc + 1));
        chk("t5_next_ptr", {32'd0, nv_ptr}, 64'h4000);
        pc = push_cnt;
        nc = nv_cnt;
        send_desc(32'h0000_1500, 32'h0000_2500, 32'h0000_0000, 32'h0000_5000, 0);
        tick(1);
        chk("t5_zero_no_push", 64'(push_cnt), 64'(pc));
        chk("t5_zero_next", 64'(nv_cnt), 64'(nc + 1));
        chk("t5_zero_next_cycle", 64'(nv_cyc), 64'(last_acc + 1));
        chk("t5_zero_next_ptr", {32'd0, nv_ptr}, 64'h5000);
        send_desc(32'h0000_1600, 32'h0000_2600, 32'hFFFF_0004, 32'h0, 0);
        tick(1);
        chk("t5_reserved_cmd", {16'd0, wr_cmd_o}, 64'h0000_0000_2600_0004);
        @(negedge clk);
        chk("t5_done", {63'd0, done_o}, 64'd1);
        tick(1);

        // Reset after beat 2
        pulse_start();
        send_beat(32'h0000_1700, 2'b00, 1'b0);
        send_beat(32'h0000_2700, 2'b00, 1'b0);
        send_beat(32'h0000_0044, 2'b00, 1'b0);
        pc  = push_cnt;
        nc  = nv_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rready", {63'd0, rready_o}, 64'd0);
        chk("t6_flags", {60'd0, next_valid_o, busy_o, done_o, err_o}, 64'd0);
        chk("t6_cmds", {rd_cmd_o[31:0], wr_cmd_o[31:0]}, 64'd0);
        chk("t6_next", {32'd0, next_ptr_o}, 64'd0);
        tick(2);
        chk("t6_no_push", 64'(push_cnt), 64'(pc));
        chk("t6_no_next", 64'(nv_cnt), 64'(nc));
        pulse_start();
        send_desc(32'h0000_7000, 32'h0000_8000, 32'h8000_0100, 32'h0, 0);
        tick(1);
        chk("t6_push_cycle", 64'(push_cyc), 64'(last_acc + 1));
        chk("t6_rd_cmd", {16'd0, rd_cmd_o}, 64'h0000_0000_7000_0100);
        @(negedge clk);
        chk("t6_done", {63'd0, done_o}, 64'd1);

        tick(3);
        chk("sb_rd_empty", 64'(exp_rd.size()), 64'd0);
        chk("sb_nv_empty", 64'(exp_nv.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
